mc_controller: RTL

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_pkg.sv | 42 ++++
 rtl/mc_controller_aludec.sv | 27 ++
 rtl/mc_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS controller and its ALU decoder.
package mc_controller_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic u1 is_legal_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps the FSM's aluop class and the R-type funct field to an ALU operation.
module aludec
    import mc_controller_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        unique case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                unique case (funct)
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM, PC enable, illegal-opcode pulse and retired-instruction counter.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             pcen,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t            r_state;
    state_t            w_next;
    state_t            w_out_state;
    logic [CNT_W-1:0]  r_instret;
    logic              w_pcwrite;
    logic              w_branch;
    logic              w_retire;
    aluop_t            w_aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = FETCH;
        unique case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_RTYPE:     w_next = EXECUTE;
                    OP_BEQ:       w_next = BRANCH;
                    OP_ADDI:      w_next = ADDIEXEC;
                    OP_J:         w_next = JUMP;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    w_next = MEMWB;
            EXECUTE:  w_next = ALUWB;
            ADDIEXEC: w_next = ADDIWB;
            default:  w_next = FETCH;
        endcase
    end

    always_comb begin
        w_retire = 1'b0;
        unique case (r_state)
            MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP: w_retire = 1'b1;
            default:                                   w_retire = 1'b0;
        endcase
    end

    // While reset is held the outputs present FETCH values with all write enables gated off.
    always_comb begin
        w_out_state = reset ? FETCH : r_state;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        pcsrc     = 2'b00;
        illegal   = 1'b0;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        w_aluop   = ALUOP_ADD;
        unique case (w_out_state)
            FETCH: begin
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = !is_legal_op(op);
            end
            MEMADR, ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB: regwrite = 1'b1;
            BRANCH: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign pcen    = !reset && (w_pcwrite || (w_branch && zero));
    assign instret = r_instret;

    aludec u_aludec (
        .aluop      (w_aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
